// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer (rst_seq_ctl).
// State encoding, legal STAGES range and counter-width helper.
package rst_seq_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      RELEASE   = 2'd1,
      RUN       = 2'd2,
      REQ       = 2'd3
   } state_t;

   localparam int STAGES_MIN = 1;
   localparam int STAGES_MAX = 8;

   // True when the number of sequenced reset outputs is supported.
   function automatic bit stages_legal(input int stages);
      return (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
   endfunction

   // Bits needed for a counter that runs 0..max_count-1 (never below 1 bit).
   function automatic int cnt_w(input int max_count);
      return (max_count < 2) ? 1 : $clog2(max_count);
   endfunction

endpackage

// File: rtl/rst_seq_ctl_bit_syn.sv
// bit_syn: generic two-flop single-bit synchroniser, reset value 0.
// Used to bring the asynchronous PLL lock into the sys_clk domain.
module bit_syn (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic r_meta;
   logic r_sync;

   // Two back-to-back flops; output is d_i delayed by two clock edges.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= d_i;
         r_sync <= r_meta;
      end
   end

   assign q_o = r_sync;

endmodule

// File: rtl/rst_seq_ctl.sv
// rst_seq_ctl: consumer-side reset sequencer in the sys_clk domain.
// Qualifies PLL lock, releases STAGES reset domains in ascending order spaced
// STAGE_DLY cycles apart, and raises rst_req_o back to the clock/reset
// controller on a software request (or watchdog expiry when RST_SEQ_WDT_EN is
// defined), holding it for at least REQ_HOLD cycles and until acknowledged.
// Handshake: rst_req_o is a level; it drops on the first cycle where the hold
// time has elapsed and rst_ack_i is high. state_o exposes the FSM state.
module rst_seq_ctl
   import rst_seq_pkg::*;
#(
   parameter int STAGES      = 3,
   parameter int STAGE_DLY   = 1000,
   parameter int LOCK_FILT   = 8,
   parameter int REQ_HOLD    = 16,
   parameter int WDT_TIMEOUT = 1048576
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              pll_locked_i,
   input  logic              sw_rst_req_i,
   input  logic              rst_ack_i,
   input  logic              wdt_kick_i,
   output logic [STAGES-1:0] rst_n_o,
   output logic              rst_req_o,
   output logic              busy_o,
   output logic              wdt_flag_o,
   output state_t            state_o
);

   localparam bit STAGES_OK = stages_legal(STAGES);
   localparam int FILT_W    = cnt_w(LOCK_FILT);
   localparam int DLY_W     = cnt_w(STAGE_DLY);
   localparam int IDX_W     = cnt_w(STAGES);
   localparam int HOLD_W    = cnt_w(REQ_HOLD);

   localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);
   localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(STAGE_DLY - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(STAGES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REQ_HOLD - 1);

   generate
      if (!STAGES_OK) begin : g_bad_stages
         $error("rst_seq_ctl: STAGES must be within 1..8");
      end
   endgenerate

   state_t              r_state, w_state;
   logic [FILT_W-1:0]   r_filt_cnt, w_filt_cnt;
   logic [DLY_W-1:0]    r_dly_cnt, w_dly_cnt;
   logic [IDX_W-1:0]    r_idx, w_idx;
   logic [HOLD_W-1:0]   r_hold_cnt, w_hold_cnt;
   logic [STAGES-1:0]   r_rst_n, w_rst_n;
   logic                r_req, w_req;
   logic                r_busy;
   logic                w_lock_s;
   logic                w_expire;

   bit_syn u_lock_syn (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .d_i     (pll_locked_i),
      .q_o     (w_lock_s)
   );

   // State, counters and registered outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= WAIT_LOCK;
         r_filt_cnt <= '0;
         r_dly_cnt  <= '0;
         r_idx      <= '0;
         r_hold_cnt <= '0;
         r_rst_n    <= '0;
         r_req      <= 1'b0;
         r_busy     <= 1'b1;
      end else begin
         r_state    <= w_state;
         r_filt_cnt <= w_filt_cnt;
         r_dly_cnt  <= w_dly_cnt;
         r_idx      <= w_idx;
         r_hold_cnt <= w_hold_cnt;
         r_rst_n    <= w_rst_n;
         r_req      <= w_req;
         r_busy     <= (w_state != RUN);
      end
   end

   // Next-state and next-output logic; lock loss outranks any request.
   always_comb begin
      w_state    = r_state;
      w_filt_cnt = r_filt_cnt;
      w_dly_cnt  = r_dly_cnt;
      w_idx      = r_idx;
      w_hold_cnt = r_hold_cnt;
      w_rst_n    = r_rst_n;
      w_req      = r_req;
      case (r_state)
         WAIT_LOCK: begin
            w_rst_n = '0;
            if (!w_lock_s) begin
               w_filt_cnt = '0;
            end else if (r_filt_cnt == FILT_LAST) begin
               w_state    = RELEASE;
               w_filt_cnt = '0;
               w_dly_cnt  = '0;
               w_idx      = '0;
            end else begin
               w_filt_cnt = r_filt_cnt + 1'b1;
            end
         end
         RELEASE, RUN: begin
            if (!w_lock_s) begin
               w_state = WAIT_LOCK;
               w_rst_n = '0;
            end else if (sw_rst_req_i || w_expire) begin
               w_state    = REQ;
               w_rst_n    = '0;
               w_req      = 1'b1;
               w_hold_cnt = '0;
            end else if (r_state == RELEASE) begin
               if (r_dly_cnt == DLY_LAST) begin
                  w_dly_cnt      = '0;
                  w_rst_n[r_idx] = 1'b1;
                  w_idx          = r_idx + 1'b1;
                  if (r_idx == IDX_LAST) begin
                     w_state = RUN;
                  end
               end else begin
                  w_dly_cnt = r_dly_cnt + 1'b1;
               end
            end
         end
         REQ: begin
            if (r_hold_cnt != HOLD_LAST) begin
               w_hold_cnt = r_hold_cnt + 1'b1;
            end else if (rst_ack_i) begin
               w_state    = WAIT_LOCK;
               w_req      = 1'b0;
               w_hold_cnt = '0;
            end
         end
         default: begin
            w_state = WAIT_LOCK;
            w_rst_n = '0;
         end
      endcase
   end

`ifdef RST_SEQ_WDT_EN
   localparam int                WDT_W    = cnt_w(WDT_TIMEOUT);
   localparam logic [WDT_W-1:0]  WDT_LAST = WDT_W'(WDT_TIMEOUT - 1);

   logic [WDT_W-1:0] r_wdt_cnt;
   logic             r_wdt_flag;
   logic             w_req_entry;

   assign w_expire    = (r_state == RUN) && (r_wdt_cnt == WDT_LAST) && !wdt_kick_i;
   assign w_req_entry = (w_state == REQ) && (r_state != REQ);

   // Watchdog counts unkicked RUN cycles; flag records the source of the last request.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_wdt_cnt  <= '0;
         r_wdt_flag <= 1'b0;
      end else begin
         if ((r_state != RUN) || wdt_kick_i || (r_wdt_cnt == WDT_LAST)) begin
            r_wdt_cnt <= '0;
         end else begin
            r_wdt_cnt <= r_wdt_cnt + 1'b1;
         end
         if (w_req_entry) begin
            r_wdt_flag <= w_expire;
         end
      end
   end

   assign wdt_flag_o = r_wdt_flag;
`else
   logic w_unused_wdt;
   assign w_expire     = 1'b0;
   assign w_unused_wdt = wdt_kick_i ^ (WDT_TIMEOUT == 0);
   assign wdt_flag_o   = 1'b0;
`endif

   assign rst_n_o   = r_rst_n;
   assign rst_req_o = r_req;
   assign busy_o    = r_busy;
   assign state_o   = r_state;

endmodule
